// File: rtl/game_sequencer_if.sv
// Signal bundle between the game sequencer and its surroundings: frame and
// button/collision event inputs, plus the phase/status outputs for the SSD and datapath.
interface game_sequencer_if;
  // Event inputs (vsync, btn_start, hit, goal) carry no handshake: each is sampled
  // every clk and acted on in the cycle it is seen. Outputs are level-valid every cycle.
  logic       vsync;
  logic       btn_start;
  logic       hit;
  logic       goal;
  logic [3:0] state;
  logic [2:0] lives;
  logic [3:0] level;
  logic       play_en;
  logic       flash;
  logic       frame_tick;

  modport master (
    output vsync, btn_start, hit, goal,
    input  state, lives, level, play_en, flash, frame_tick
  );

  modport slave (
    input  vsync, btn_start, hit, goal,
    output state, lives, level, play_en, flash, frame_tick
  );
endinterface

// File: rtl/game_sequencer.sv
// Game-flow controller: phase FSM, lives/level tracking and frame-timed phases.
// All outputs come straight from registers; state is exposed as the 4-bit phase code.
module game_sequencer #(
  parameter int LIVES_INIT   = 3,
  parameter int READY_FRAMES = 120,
  parameter int HIT_FRAMES   = 60,
  parameter int LVL_FRAMES   = 90,
  parameter int MAX_LEVEL    = 9,
  parameter int FCW          = 8
) (
  input logic            clk,
  input logic            rst_n,
  game_sequencer_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_READY    = 4'd1,
    S_PLAY     = 4'd2,
    S_HIT      = 4'd3,
    S_LVLUP    = 4'd4,
    S_GAMEOVER = 4'd5,
    S_WIN      = 4'd6,
    S_PAUSE    = 4'd7
  } state_t;

  localparam logic [FCW-1:0] READY_LOAD = FCW'(READY_FRAMES - 1);
  localparam logic [FCW-1:0] HIT_LOAD   = FCW'(HIT_FRAMES - 1);
  localparam logic [FCW-1:0] LVL_LOAD   = FCW'(LVL_FRAMES - 1);
  localparam logic [2:0]     LIVES_RST  = 3'(LIVES_INIT);
  localparam logic [3:0]     MAX_LVL    = 4'(MAX_LEVEL);

  state_t         state_q, state_d;
  logic [FCW-1:0] cnt_q, cnt_d;
  logic [2:0]     lives_q, lives_d;
  logic [3:0]     level_q, level_d;
  logic           play_en_q, play_en_d;
  logic           flash_q, flash_d;
  logic           frame_tick_q;
  logic           vsync_q;
  logic           btn_s1, btn_s2, btn_s3;
  logic           start_p;

  // vsync idles high, so its history resets high to avoid a spurious tick after reset.
  assign start_p = btn_s2 & ~btn_s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      lives_q      <= LIVES_RST;
      level_q      <= 4'd1;
      play_en_q    <= 1'b0;
      flash_q      <= 1'b0;
      frame_tick_q <= 1'b0;
      vsync_q      <= 1'b1;
      btn_s1       <= 1'b0;
      btn_s2       <= 1'b0;
      btn_s3       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lives_q      <= lives_d;
      level_q      <= level_d;
      play_en_q    <= play_en_d;
      flash_q      <= flash_d;
      frame_tick_q <= bus.vsync & ~vsync_q;
      vsync_q      <= bus.vsync;
      btn_s1       <= bus.btn_start;
      btn_s2       <= btn_s1;
      btn_s3       <= btn_s2;
    end
  end

  // Timed phases count down on frame_tick and leave after the tick that sees cnt==0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lives_d = lives_q;
    level_d = level_q;
    case (state_q)
      S_IDLE: begin
        if (start_p) begin
          state_d = S_READY;
          lives_d = LIVES_RST;
          level_d = 4'd1;
          cnt_d   = READY_LOAD;
        end
      end
      S_READY: begin
        if (frame_tick_q) begin
          if (cnt_q == '0) state_d = S_PLAY;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      S_PLAY: begin
        if (bus.hit) begin
          lives_d = lives_q - 3'd1;
          if (lives_q == 3'd1) begin
            state_d = S_GAMEOVER;
          end else begin
            state_d = S_HIT;
            cnt_d   = HIT_LOAD;
          end
        end else if (bus.goal) begin
          if (level_q == MAX_LVL) begin
            state_d = S_WIN;
          end else begin
            level_d = level_q + 4'd1;
            state_d = S_LVLUP;
            cnt_d   = LVL_LOAD;
          end
        end else if (start_p) begin
          state_d = S_PAUSE;
        end
      end
      S_HIT: begin
        if (frame_tick_q) begin
          if (cnt_q == '0) state_d = S_PLAY;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      S_LVLUP: begin
        if (frame_tick_q) begin
          if (cnt_q == '0) begin
            state_d = S_READY;
            cnt_d   = READY_LOAD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      S_PAUSE: begin
        if (start_p) state_d = S_PLAY;
      end
      S_GAMEOVER, S_WIN: begin
        if (start_p) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so their registers line up with state_q.
  always_comb begin
    play_en_d = (state_d == S_PLAY) || (state_d == S_HIT);
    flash_d   = (state_d == S_HIT) && cnt_d[2];
  end

  assign bus.state      = state_q;
  assign bus.lives      = lives_q;
  assign bus.level      = level_q;
  assign bus.play_en    = play_en_q;
  assign bus.flash      = flash_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: short timed phases, MAX_LEVEL=2, hand-computed
// expectations checked with immediate assertions.
module tb_game_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  game_sequencer_if gif ();

  game_sequencer #(
    .LIVES_INIT  (3),
    .READY_FRAMES(3),
    .HIT_FRAMES  (6),
    .LVL_FRAMES  (2),
    .MAX_LEVEL   (2),
    .FCW         (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (gif)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks; each returns at a falling edge once the DUT has reacted
  task automatic tick();
    @(negedge clk) gif.vsync = 1'b0;
    @(negedge clk) gif.vsync = 1'b1;
    @(negedge clk);
    chk("frame_tick_hi", 8'(gif.frame_tick), 8'd1);
    @(negedge clk);
    chk("frame_tick_lo", 8'(gif.frame_tick), 8'd0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press();
    @(negedge clk) gif.btn_start = 1'b1;
    repeat (3) @(negedge clk);
    gif.btn_start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse(input logic h, input logic g);
    @(negedge clk);
    gif.hit  = h;
    gif.goal = g;
    @(negedge clk);
    gif.hit  = 1'b0;
    gif.goal = 1'b0;
  endtask

  task automatic chk_status(input string tag, input logic [3:0] st, input logic [2:0] lv,
                            input logic [3:0] lvl, input logic pe);
    chk({tag, "_state"}, 8'(gif.state), 8'(st));
    chk({tag, "_lives"}, 8'(gif.lives), 8'(lv));
    chk({tag, "_level"}, 8'(gif.level), 8'(lvl));
    chk({tag, "_play_en"}, 8'(gif.play_en), 8'(pe));
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    gif.vsync     = 1'b1;
    gif.btn_start = 1'b0;
    gif.hit       = 1'b0;
    gif.goal      = 1'b0;
    repeat (3) @(negedge clk);
    chk_status("reset", 4'd0, 3'd3, 4'd1, 1'b0);
    chk("reset_flash", 8'(gif.flash), 8'd0);
    chk("reset_frame_tick", 8'(gif.frame_tick), 8'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_tick", 8'(gif.frame_tick), 8'd0);

    // start: READY lasts exactly 3 ticks, no movement without ticks
    press();
    chk_status("start", 4'd1, 3'd3, 4'd1, 1'b0);
    repeat (20) @(negedge clk);
    chk("ready_no_tick_hold", 8'(gif.state), 8'd1);
    ticks(2);
    chk("ready_after2", 8'(gif.state), 8'd1);
    tick();
    chk_status("play", 4'd2, 3'd3, 4'd1, 1'b1);

    // hit: HIT lasts 6 ticks, invulnerable, flash follows cnt[2] (5,4 -> 1; 3 -> 0)
    pulse(1'b1, 1'b0);
    chk_status("hit1", 4'd3, 3'd2, 4'd1, 1'b1);
    chk("hit1_flash", 8'(gif.flash), 8'd1);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    press();
    chk_status("hit_ignored", 4'd3, 3'd2, 4'd1, 1'b1);
    tick();
    chk("hit_flash_cnt4", 8'(gif.flash), 8'd1);
    tick();
    chk("hit_flash_cnt3", 8'(gif.flash), 8'd0);
    ticks(3);
    chk("hit_after5", 8'(gif.state), 8'd3);
    tick();
    chk_status("hit_exit", 4'd2, 3'd2, 4'd1, 1'b1);
    chk("play_flash", 8'(gif.flash), 8'd0);

    // simultaneous hit and goal: hit wins, level unchanged
    pulse(1'b1, 1'b1);
    chk_status("both", 4'd3, 3'd1, 4'd1, 1'b1);
    ticks(6);
    chk("both_exit", 8'(gif.state), 8'd2);

    // goal: LVLUP 2 ticks, then READY 3 ticks, then PLAY
    pulse(1'b0, 1'b1);
    chk_status("lvlup", 4'd4, 3'd1, 4'd2, 1'b0);
    tick();
    chk("lvlup_after1", 8'(gif.state), 8'd4);
    tick();
    chk("lvlup_to_ready", 8'(gif.state), 8'd1);
    ticks(2);
    chk("ready2_after2", 8'(gif.state), 8'd1);
    tick();
    chk_status("play2", 4'd2, 3'd1, 4'd2, 1'b1);

    // long press: exactly one PAUSE; pause ignores ticks, hit and goal
    @(negedge clk) gif.btn_start = 1'b1;
    repeat (1000) @(negedge clk);
    chk("pause_held", 8'(gif.state), 8'd7);
    gif.btn_start = 1'b0;
    repeat (3) @(negedge clk);
    ticks(2);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    chk_status("pause", 4'd7, 3'd1, 4'd2, 1'b0);
    press();
    chk_status("resume", 4'd2, 3'd1, 4'd2, 1'b1);

    // goal at MAX_LEVEL wins; values hold through IDLE until the next start
    pulse(1'b0, 1'b1);
    chk_status("win", 4'd6, 3'd1, 4'd2, 1'b0);
    press();
    chk_status("win_idle", 4'd0, 3'd1, 4'd2, 1'b0);
    press();
    chk_status("restart", 4'd1, 3'd3, 4'd1, 1'b0);
    ticks(3);
    chk("restart_play", 8'(gif.state), 8'd2);

    // game over after three hits
    pulse(1'b1, 1'b0);
    ticks(6);
    pulse(1'b1, 1'b0);
    chk("go_lives1", 8'(gif.lives), 8'd1);
    ticks(6);
    pulse(1'b1, 1'b0);
    chk_status("gameover", 4'd5, 3'd0, 4'd1, 1'b0);
    press();
    chk_status("go_idle", 4'd0, 3'd0, 4'd1, 1'b0);

    // asynchronous reset in the middle of HIT
    press();
    press();
    pulse(1'b0, 1'b0);
    chk("pre_rst_ready", 8'(gif.state), 8'd1);
    ticks(3);
    pulse(1'b0, 1'b1);
    ticks(2);
    ticks(3);
    pulse(1'b1, 1'b0);
    chk_status("pre_rst_hit", 4'd3, 3'd2, 4'd2, 1'b1);
    chk("pre_rst_flash", 8'(gif.flash), 8'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_status("async_rst", 4'd0, 3'd3, 4'd1, 1'b0);
    chk("async_rst_flash", 8'(gif.flash), 8'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_state", 8'(gif.state), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
